// File: rtl/cola_fifo_param.sv
// -----------------------------------------------------------------------------
// cola_fifo_param
// Parametrised single-clock FIFO queue built on a register-file store
// (synchronous write, asynchronous read). Tracks occupancy in a dedicated
// counter, decodes empty/full/almost thresholds from it, and keeps sticky
// overflow/underflow flags. Output is either first-word-fall-through
// (FWFT=1) or a register loaded on each accepted read (FWFT=0).
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset of all control state
//   wr, w_data   write request and data to enqueue
//   rd           read (pop) request
//   r_data       dequeued data (head word when FWFT=1, last popped when FWFT=0)
//   clr_err      synchronous clear of the sticky error flags
//   count        words stored, 0..2**A
//   empty/full   count == 0 / count == 2**A
//   almost_empty count <= AE_THR
//   almost_full  count >= AF_THR
//   overflow     sticky: a write was rejected
//   underflow    sticky: a read was rejected
// -----------------------------------------------------------------------------
module cola_fifo_param #(
    parameter int W      = 8,
    parameter int A      = 4,
    parameter int AF_THR = 14,
    parameter int AE_THR = 2,
    parameter int FWFT   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] w_data,
    input  logic         rd,
    output logic [W-1:0] r_data,
    input  logic         clr_err,
    output logic [A:0]   count,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic         overflow,
    output logic         underflow
);

    localparam int         D      = 1 << A;
    localparam logic [A:0] D_C    = (A+1)'(D);
    localparam logic [A:0] AF_C   = (A+1)'(AF_THR);
    localparam logic [A:0] AE_C   = (A+1)'(AE_THR);

    logic [W-1:0] mem_q [D];
    logic [A-1:0] wp_q, wp_d;
    logic [A-1:0] rp_q, rp_d;
    logic [A:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         wa, ra;

    // Status outputs are pure decodes of the occupancy counter.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == D_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    always_comb begin
        // A write into a full queue is still accepted when a pop frees the
        // head slot in the same cycle.
        wa      = wr & (~full | rd);
        ra      = rd & ~empty;
        wp_d    = wa ? wp_q + 1'b1 : wp_q;
        rp_d    = ra ? rp_q + 1'b1 : rp_q;
        count_d = count_q;
        if (wa && !ra) begin
            count_d = count_q + 1'b1;
        end else if (ra && !wa) begin
            count_d = count_q - 1'b1;
        end
        // A fresh error outranks a coincident clear.
        ovf_d   = (ovf_q & ~clr_err) | (wr & ~wa);
        unf_d   = (unf_q & ~clr_err) | (rd & ~ra);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately not reset; stale words are never exposed
    // because the pointers and count are.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem_q[wp_q] <= w_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = mem_q[rp_q];
        end else begin : g_reg
            logic [W-1:0] rdata_q, rdata_d;

            // Read of the old head happens before a same-edge write can
            // overwrite that slot (full with rd&wr).
            always_comb begin
                rdata_d = ra ? mem_q[rp_q] : rdata_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= rdata_d;
                end
            end

            assign r_data = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_cola_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_cola_fifo_param
// Drives one FWFT=1 and one FWFT=0 instance with identical stimulus and
// compares both against a queue-based reference model of the FIFO rules.
// -----------------------------------------------------------------------------
module tb_cola_fifo_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] w_data = '0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] r_data1, r_data0;
    logic [4:0] count1, count0;
    logic       empty1, full1, ae1, af1, ovf1, unf1;
    logic       empty0, full0, ae0, af0, ovf0, unf0;

    always #5 clk = ~clk;

    cola_fifo_param #(.W(8), .A(4), .AF_THR(14), .AE_THR(2), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data1), .clr_err(clr_err), .count(count1), .empty(empty1),
        .full(full1), .almost_empty(ae1), .almost_full(af1),
        .overflow(ovf1), .underflow(unf1)
    );

    cola_fifo_param #(.W(8), .A(4), .AF_THR(14), .AE_THR(2), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data0), .clr_err(clr_err), .count(count0), .empty(empty0),
        .full(full0), .almost_empty(ae0), .almost_full(af0),
        .overflow(ovf0), .underflow(unf0)
    );

    // Reference model: plain queue plus sticky bits and the popped-word register.
    logic [7:0] mq[$];
    logic       m_ovf, m_unf;
    logic [7:0] m_r0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_r0  = 8'h00;
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic r, input logic c);
        int  n;
        bit  wa, ra;
        n  = mq.size();
        wa = w && ((n != 16) || r);
        ra = r && (n != 0);
        if (ra) m_r0 = mq.pop_front();
        if (wa) mq.push_back(d);
        m_ovf = (m_ovf && !c) || (w && !wa);
        m_unf = (m_unf && !c) || (r && !ra);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ":count1"}, 32'(count1), 32'(n));
        chk({tag, ":count0"}, 32'(count0), 32'(n));
        chk({tag, ":empty"},  {30'd0, empty1, empty0}, {30'd0, n == 0, n == 0});
        chk({tag, ":full"},   {30'd0, full1, full0},   {30'd0, n == 16, n == 16});
        chk({tag, ":aempty"}, {30'd0, ae1, ae0},       {30'd0, n <= 2, n <= 2});
        chk({tag, ":afull"},  {30'd0, af1, af0},       {30'd0, n >= 14, n >= 14});
        chk({tag, ":ovf"},    {30'd0, ovf1, ovf0},     {30'd0, m_ovf, m_ovf});
        chk({tag, ":unf"},    {30'd0, unf1, unf0},     {30'd0, m_unf, m_unf});
        chk({tag, ":rdata0"}, 32'(r_data0), 32'(m_r0));
        if (n != 0) chk({tag, ":rdata1"}, 32'(r_data1), 32'(mq[0]));
    endtask

    // One clock of stimulus: drive, let the edge happen, update model, sample.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        wr = w; w_data = d; rd = r; clr_err = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
        check_all(tag);
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        int pw, pr;
        model_reset();
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        chk("reset:rdata0_zero", 32'(r_data0), 32'h0);
        reset = 1'b0;

        // Basic ordering
        step("w11", 1'b1, 8'h11, 1'b0, 1'b0);
        step("w22", 1'b1, 8'h22, 1'b0, 1'b0);
        step("w33", 1'b1, 8'h33, 1'b0, 1'b0);
        chk("basic:head", 32'(r_data1), 32'h11);
        chk("basic:count", 32'(count1), 32'd3);
        for (int i = 0; i < 3; i++) step("rd3", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic:last_pop", 32'(r_data0), 32'h33);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf:flag", 32'(ovf1), 32'd1);
        chk("ovf:count", 32'(count1), 32'd16);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain:last", 32'(r_data0), 32'h0F);
        step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

        // Wrap-around
        for (int i = 0; i < 10; i++) step("wrapw", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("wrapr", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step("wrapw2", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step("wrapr2", 1'b0, 8'h00, 1'b1, 1'b0);

        // Full with simultaneous rd&wr
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step("fullrw", 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("fullrw:count", 32'(count1), 32'd16);
        chk("fullrw:pop", 32'(r_data0), 32'h20);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullrw:last", 32'(r_data0), 32'h5A);

        // Empty with simultaneous rd&wr
        step("emptyrw", 1'b1, 8'hC3, 1'b1, 1'b0);
        chk("emptyrw:data", 32'(r_data1), 32'hC3);
        chk("emptyrw:unf", 32'(unf1), 32'd1);
        step("clr2", 1'b0, 8'h00, 1'b0, 1'b1);
        step("popc3", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_vs_err", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("clr_vs_err:unf", 32'(unf1), 32'd1);
        step("clr3", 1'b0, 8'h00, 1'b0, 1'b1);

        // Registered-output behaviour
        step("r0w1", 1'b1, 8'h11, 1'b0, 1'b0);
        step("r0w2", 1'b1, 8'h22, 1'b0, 1'b0);
        step("r0rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("r0:first", 32'(r_data0), 32'h11);
        step("r0hold", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("r0:hold", 32'(r_data0), 32'h11);
        step("r0rd2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("r0:second", 32'(r_data0), 32'h22);

        // Reset mid-stream, then first write lands at the start
        for (int i = 0; i < 5; i++) step("prerst", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step("prerst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        async_reset("midrst");
        step("postrst", 1'b1, 8'h77, 1'b0, 1'b0);
        chk("postrst:head", 32'(r_data1), 32'h77);

        // Randomized traffic with alternating bias and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ((i / 60) % 2 == 0) begin pw = 80; pr = 35; end
            else                   begin pw = 35; pr = 80; end
            if ($urandom_range(0, 199) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 99) < pw), 8'($urandom),
                     ($urandom_range(0, 99) < pr), ($urandom_range(0, 15) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cola_fifo_param.md
# cola_fifo_param

Parametrised synchronous FIFO queue built around a register-file store with synchronous write and asynchronous read. Depth and word width are set by parameters. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable output mode (first-word-fall-through or registered). It is the queue primitive of the Cola_fifo design, sitting between a producer and a consumer in the same clock domain.

## Interface
- W, 8, data word width in bits
- A, 4, address bits; depth D = 2**A words
- AF_THR, 14, almost_full asserted when count >= AF_THR (valid range 1..D)
- AE_THR, 2, almost_empty asserted when count <= AE_THR (valid range 0..D-1)
- FWFT, 1, 1 = r_data shows the head word combinationally; 0 = r_data is registered and loaded on an accepted read

- clk  in  1  single clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- wr  in  1  write request
- w_data  in  W  data to enqueue
- rd  in  1  read request (pop)
- r_data  out  W  dequeued data (see Operation)
- clr_err  in  1  synchronous clear of overflow/underflow
- count  out  A+1  words currently stored, 0..D
- empty  out  1  count == 0
- full  out  1  count == D
- almost_empty  out  1  count <= AE_THR
- almost_full  out  1  count >= AF_THR
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Storage: D x W register array; write pointer wp and read pointer rp, A bits each, wrap modulo D naturally; count held as an A+1-bit register (not derived from pointers).
- Accepted write (wa) = wr & (!full | rd). Accepted read (ra) = rd & !empty.
- wa: array[wp] <= w_data, wp <= wp+1. ra: rp <= rp+1.
- count: +1 on wa&!ra, -1 on ra&!wa, unchanged otherwise.
- Simultaneous rd&wr when empty: write accepted, read rejected, underflow set, count 0->1.
- Simultaneous rd&wr when full: both accepted; head word read out before the slot is overwritten; count stays D.
- wr when full and no rd: data dropped, no pointer change, overflow set.
- rd when empty: no pointer change, underflow set.
- FWFT=1: r_data = array[rp] combinationally; value is don't-care while empty.
- FWFT=0: on ra, r_data register <= array[rp]; holds otherwise.
- Sticky flags: set on error cycle; clr_err clears both on next edge; a new error in the same cycle as clr_err wins (flag stays 1).
- All status outputs (empty, full, almost_*) are combinational decodes of count.

## Timing
- Reset values: wp=rp=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_THR>=1), overflow=underflow=0, r_data register (FWFT=0) = 0. Array contents are not reset.
- Reset mid-operation: queue discarded immediately; first write after release is stored at address 0.
- Write-to-read latency: word written at edge N is visible on r_data (FWFT=1) and empty deasserted after edge N; earliest accepted read is edge N+1.
- FWFT=0: r_data valid one cycle after the read edge; next head not visible until next read.
- Flags and count update on the same edge as the pointer change; no extra pipeline stage.

## Test plan
- Reset then write 0x11,0x22,0x33 on three cycles -> count=3, empty=0, FWFT=1 r_data=0x11; three reads return 0x11,0x22,0x33 in order, empty=1 after the third.
- Fill with 16 writes (0x00..0x0F) -> full=1, almost_full=1 from count=14; 17th write 0xAA alone -> overflow=1, count=16; drain returns 0x00..0x0F, no 0xAA.
- Wrap-around: write 10, read 10, write 12, read 12 -> data in order, count returns 0, pointers cross address 15->0 without loss.
- Full with rd&wr (w_data=0x5A) -> count stays 16, head popped, 0x5A read last after drain; empty with rd&wr (0xC3) -> count=1, underflow=1, r_data=0xC3.
- clr_err with no error clears both sticky flags next edge; clr_err coincident with rd on empty -> underflow stays 1.
- FWFT=0 build: write 0x11,0x22, rd pulse -> r_data=0x11 one cycle later, holds until next rd, then 0x22; assert reset mid-stream -> count=0, r_data=0, empty=1 asynchronously.
